// File: rtl/target_feeder.sv
// Serialises packed 2-bit target bases onto the systolic array input, one per clock,
// then holds the array idle for LENGTH cycles to drain before pulsing done.
module target_feeder #(
    parameter int WORD_WIDTH = 32,
    parameter int LENGTH     = 128,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  target_len,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_vld,
    output logic                  word_rdy,
    output logic [1:0]            data_out,
    output logic                  en_out,
    output logic                  last_out,
    output logic                  busy,
    output logic                  done
);

    localparam int BPW    = WORD_WIDTH / 2;
    localparam int WCNT_W = $clog2(BPW + 1);
    localparam int DCNT_W = $clog2(LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN
    } state_t;

    state_t                state, state_nx;
    logic [LEN_WIDTH-1:0]  rem, rem_nx;
    logic [WORD_WIDTH-1:0] sreg, sreg_nx;
    logic [WCNT_W-1:0]     wcnt, wcnt_nx;
    logic [DCNT_W-1:0]     dcnt, dcnt_nx;
    logic [1:0]            data_nx;
    logic                  en_nx;
    logic                  last_nx;
    logic                  busy_nx;
    logic                  done_nx;
    logic                  word_end;
    logic                  seq_end;

    assign word_end = (wcnt == WCNT_W'(1));
    assign seq_end  = (rem == LEN_WIDTH'(1));

    // Refill is only offered while more bases remain beyond the one going out now,
    // so surplus upstream words stay pending for the next sequence.
    assign word_rdy = (state == LOAD) ||
                      ((state == STREAM) && word_end && (rem > LEN_WIDTH'(1)));

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        sreg_nx  = sreg;
        wcnt_nx  = wcnt;
        dcnt_nx  = dcnt;
        data_nx  = data_out;
        en_nx    = en_out;
        last_nx  = 1'b0;
        busy_nx  = busy;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (target_len != '0) begin
                        rem_nx   = target_len;
                        busy_nx  = 1'b1;
                        state_nx = LOAD;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end

            LOAD: begin
                en_nx = 1'b0;
                if (word_vld) begin
                    sreg_nx  = word_in;
                    wcnt_nx  = WCNT_W'(BPW);
                    state_nx = STREAM;
                end
            end

            STREAM: begin
                data_nx = sreg[1:0];
                en_nx   = 1'b1;
                sreg_nx = sreg >> 2;
                wcnt_nx = wcnt - WCNT_W'(1);
                rem_nx  = rem - LEN_WIDTH'(1);
                if (seq_end) begin
                    last_nx  = 1'b1;
                    dcnt_nx  = DCNT_W'(LENGTH);
                    state_nx = DRAIN;
                end else if (word_end) begin
                    // Back-to-back refill keeps the base stream contiguous.
                    if (word_vld) begin
                        sreg_nx = word_in;
                        wcnt_nx = WCNT_W'(BPW);
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end

            DRAIN: begin
                en_nx   = 1'b0;
                data_nx = 2'b00;
                dcnt_nx = dcnt - DCNT_W'(1);
                if (dcnt == DCNT_W'(1)) begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rem      <= '0;
            sreg     <= '0;
            wcnt     <= '0;
            dcnt     <= '0;
            data_out <= '0;
            en_out   <= 1'b0;
            last_out <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            rem      <= rem_nx;
            sreg     <= sreg_nx;
            wcnt     <= wcnt_nx;
            dcnt     <= dcnt_nx;
            data_out <= data_nx;
            en_out   <= en_nx;
            last_out <= last_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_target_feeder.sv
// Directed bench for target_feeder: base order, handshakes, bubbles, drain timing, reset abort.
module tb_target_feeder;

    localparam int WW  = 32;
    localparam int LEN = 8;
    localparam int LW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] target_len;
    logic [WW-1:0] word_in;
    logic          word_vld;
    logic          word_rdy;
    logic [1:0]    data_out;
    logic          en_out;
    logic          last_out;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    target_feeder #(
        .WORD_WIDTH(WW),
        .LENGTH    (LEN),
        .LEN_WIDTH (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .target_len(target_len),
        .word_in   (word_in),
        .word_vld  (word_vld),
        .word_rdy  (word_rdy),
        .data_out  (data_out),
        .en_out    (en_out),
        .last_out  (last_out),
        .busy      (busy),
        .done      (done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got_v, input int exp_v);
        n_chk++;
        if (got_v == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
    endtask

    logic [WW-1:0] words [4];
    logic [1:0]    got [$];
    bit            vld_en, seen_en, saw_last, busy_c1, rdy_c1;
    int cyc, widx, lo_a, lo_b, pulse_cyc, pulse_len;
    int n_hs, n_rdy, n_busy, n_done, n_last, last_at, last_cyc, done_cyc;
    int first_cyc, gap_run, bubbles, gap_at;

    task automatic mon_clear();
        got.delete();
        n_hs = 0; n_rdy = 0; n_busy = 0; n_done = 0; n_last = 0;
        last_at = -1; last_cyc = -1; done_cyc = -1; first_cyc = -1;
        gap_run = 0; bubbles = 0; gap_at = -1;
        seen_en = 0; saw_last = 0; busy_c1 = 0; rdy_c1 = 0;
    endtask

    // Observe at negedge, then advance the word source and drive inputs just after posedge.
    task automatic tick();
        bit hs;
        @(negedge clk);
        hs = word_vld && word_rdy;
        if (hs) n_hs++;
        if (word_rdy) n_rdy++;
        if (busy) n_busy++;
        if (cyc == 1) begin busy_c1 = busy; rdy_c1 = word_rdy; end
        if (en_out) begin
            if (seen_en && gap_run > 0) begin bubbles += gap_run; gap_at = got.size(); end
            if (!seen_en) first_cyc = cyc;
            gap_run = 0;
            seen_en = 1;
            got.push_back(data_out);
        end else if (seen_en && !saw_last) begin
            gap_run++;
        end
        if (last_out) begin n_last++; last_at = got.size(); last_cyc = cyc; saw_last = 1; end
        if (done) begin n_done++; done_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) widx++;
        start = 1'b0;
        if (cyc == pulse_cyc) begin start = 1'b1; target_len = LW'(pulse_len); end
        word_in  = words[widx % 4];
        word_vld = vld_en && !(cyc >= lo_a && cyc <= lo_b);
    endtask

    task automatic begin_seq(input int len);
        mon_clear();
        widx       = 0;
        cyc        = 0;
        word_in    = words[0];
        word_vld   = vld_en && !(lo_a <= 0 && lo_b >= 0);
        start      = 1'b1;
        target_len = LW'(len);
    endtask

    task automatic run_seq(input int len, input int budget);
        int n;
        begin_seq(len);
        n = 0;
        while (n_done == 0 && n < budget) begin tick(); n++; end
        check("done_within_budget", int'(n_done > 0), 1);
        repeat (3) tick();
    endtask

    function automatic int data_errs(input int n);
        int e;
        e = 0;
        for (int i = 0; i < n; i++) begin
            logic [WW-1:0] w;
            w = words[(i / 16) % 4];
            if (i >= got.size()) e++;
            else if (got[i] !== w[2*(i%16) +: 2]) e++;
        end
        return e;
    endfunction

    int exp5 [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b0; start = 1'b0; target_len = '0; word_in = '0; word_vld = 1'b0;
        vld_en = 0; lo_a = 1000; lo_b = 1000; pulse_cyc = -1; pulse_len = 0; cyc = 0; widx = 0;
        words[0] = 32'hE4E4_1B1B; words[1] = 32'h0F0F_F0F0;
        words[2] = 32'h3C5A_A5C3; words[3] = 32'h1234_5678;
        mon_clear();
        #1 rst = 1'b1;
        #11;
        check("rst_data_out", int'(data_out), 0);
        check("rst_en_out",   int'(en_out),   0);
        check("rst_last_out", int'(last_out), 0);
        check("rst_busy",     int'(busy),     0);
        check("rst_done",     int'(done),     0);
        check("rst_word_rdy", int'(word_rdy), 0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        // Reset mid-stream with stimulus active
        vld_en = 1;
        begin_seq(20);
        repeat (8) tick();
        check("pre_rst_en_out", int'(en_out), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_data_out", int'(data_out), 0);
        check("arst_en_out",   int'(en_out),   0);
        check("arst_busy",     int'(busy),     0);
        check("arst_word_rdy", int'(word_rdy), 0);
        #2 rst = 1'b0;
        mon_clear();
        repeat (6) tick();
        check("post_rst_no_rdy", n_rdy, 0);
        check("post_rst_no_en", got.size(), 0);

        // Five bases from a single word
        words[0] = 32'h0000_00E4;
        run_seq(5, 200);
        check("t1_count", got.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t1_base%0d", i), (got.size() > i) ? int'(got[i]) : -1, exp5[i]);
        check("t1_last_at", last_at, 5);
        check("t1_last_cnt", n_last, 1);
        check("t1_first_cyc", first_cyc, 3);
        check("t1_busy_c1", int'(busy_c1), 1);
        check("t1_rdy_c1", int'(rdy_c1), 1);
        check("t1_done_gap", done_cyc - last_cyc, LEN);
        check("t1_handshakes", n_hs, 1);
        check("t1_done_cnt", n_done, 1);
        check("t1_busy_after", int'(busy), 0);

        // Forty bases, word_vld held high
        words[0] = 32'hE4E4_1B1B;
        run_seq(40, 200);
        check("t2_count", got.size(), 40);
        check("t2_data_errs", data_errs(40), 0);
        check("t2_bubbles", bubbles, 0);
        check("t2_handshakes", n_hs, 3);
        check("t2_last_at", last_at, 40);
        check("t2_done_cnt", n_done, 1);

        // Exactly one word's worth: no refill offered on the final base
        run_seq(16, 200);
        check("t2b_count", got.size(), 16);
        check("t2b_handshakes", n_hs, 1);
        check("t2b_done_cnt", n_done, 1);

        // word_vld low for 3 cycles from the wcnt==1 cycle of word 0
        lo_a = 17; lo_b = 19;
        run_seq(32, 200);
        lo_a = 1000; lo_b = 1000;
        check("t3_count", got.size(), 32);
        check("t3_data_errs", data_errs(32), 0);
        check("t3_bubbles", bubbles, 3);
        check("t3_gap_at", gap_at, 16);
        check("t3_handshakes", n_hs, 2);

        // Zero-length request
        run_seq(0, 20);
        check("t4_done_cnt", n_done, 1);
        check("t4_done_cyc", done_cyc, 1);
        check("t4_no_rdy", n_rdy, 0);
        check("t4_no_en", got.size(), 0);
        check("t4_no_busy", n_busy, 0);

        // start while streaming is ignored
        pulse_cyc = 6; pulse_len = 3;
        run_seq(20, 200);
        pulse_cyc = -1;
        check("t4b_count", got.size(), 20);
        check("t4b_data_errs", data_errs(20), 0);
        check("t4b_last_at", last_at, 20);
        check("t4b_done_cnt", n_done, 1);
        check("t4b_handshakes", n_hs, 2);

        // Reset during DRAIN, then a fresh three-base run
        begin_seq(4);
        for (int n = 0; n < 50 && n_last == 0; n++) tick();
        repeat (2) tick();
        check("t5_in_drain_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        run_seq(3, 100);
        check("t5_count", got.size(), 3);
        check("t5_data_errs", data_errs(3), 0);
        check("t5_done_cnt", n_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/target_feeder.md
# target_feeder

Transmit-side partner of the scoring bank. It takes packed 2-bit target bases from an upstream word buffer over a valid/ready handshake and serialises them one base per clock onto the `data_in`/`en_in` pair that drives the first processing element of the systolic array. After the last base of each target sequence it holds `en_out` low for `LENGTH` cycles so the array drains, then pulses `done`.

## Interface
Parameters:
- `WORD_WIDTH`, 32: packed input word width. Must be even. `BPW = WORD_WIDTH/2` bases per word.
- `LENGTH`, 128: number of processing elements; sets the drain length in cycles.
- `LEN_WIDTH`, 16: width of the target-length field.

Ports (one clock; reset is asynchronous and active-high; ports named `clk` and `rst`):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to stream a new target sequence.
- `target_len`  in  LEN_WIDTH  number of bases in the sequence; sampled when `start` is accepted.
- `word_in`  in  WORD_WIDTH  packed bases; base 0 is `[1:0]`, base 1 is `[3:2]`, and so on.
- `word_vld`  in  1  `word_in` is valid.
- `word_rdy`  out  1  feeder accepts `word_in` this cycle.
- `data_out`  out  2  target base, encoded A=00, G=01, T=10, C=11 (passed through unchanged).
- `en_out`  out  1  `data_out` is a valid base.
- `last_out`  out  1  marks the final base of the sequence.
- `busy`  out  1  high from `start` acceptance until `done`.
- `done`  out  1  one-cycle pulse when the drain completes.

## Operation
- Registers:
  - `state` ∈ {IDLE, LOAD, STREAM, DRAIN}
  - `rem` (LEN_WIDTH): bases not yet emitted
  - `sreg` (WORD_WIDTH): shift register
  - `wcnt` (0..BPW): bases remaining in `sreg`
  - `dcnt` (0..LENGTH): drain counter
- All outputs are registered except `word_rdy`, which is combinational:
  - `word_rdy = (state==LOAD) | (state==STREAM & wcnt==1 & rem>1)`
- IDLE:
  - `start` with `target_len>0`: `rem<=target_len`, go to LOAD, `busy<=1`.
  - `start` with `target_len==0`: `done<=1` next cycle, stay in IDLE, `busy` stays 0.
- LOAD:
  - `en_out<=0`.
  - On `word_vld & word_rdy`: `sreg<=word_in`, `wcnt<=BPW`, go to STREAM.
- STREAM, every edge:
  - `data_out<=sreg[1:0]`, `en_out<=1`, `sreg<=sreg>>2`, `wcnt--`, `rem--`.
  - If `rem==1`: `last_out<=1`, `dcnt<=LENGTH`, go to DRAIN. Unused bases left in `sreg` are discarded.
  - Else if `wcnt==1` and a word is accepted: `sreg<=word_in`, `wcnt<=BPW`, stay in STREAM. No bubble.
  - Else if `wcnt==1` and no word is accepted: go to LOAD.
- DRAIN:
  - `en_out<=0`, `last_out<=0`, `data_out<=0`, `dcnt--`.
  - When `dcnt==1`: `done<=1`, `busy<=0`, go to IDLE.
- Outside the cycle it is set, `last_out` is 0. `done` is high for exactly one cycle.
- `start` is ignored while `busy`; no state change.
- `word_rdy` is never asserted after the word holding the final base has been accepted. Surplus upstream words remain pending for the next sequence.
- `rst` asserted: immediately (asynchronously) state=IDLE; all counters, `sreg`, `data_out`, `en_out`, `last_out`, `busy` and `done` go to 0. A partially streamed sequence is abandoned.

## Timing
- Reset values: `data_out=0`, `en_out=0`, `last_out=0`, `busy=0`, `done=0`, `word_rdy=0`.
- `start` accepted at edge k: `busy` is high from cycle k+1 and `word_rdy` is high from cycle k+1 (LOAD).
- Word accepted at edge j from LOAD: first base is on `data_out` with `en_out=1` in cycle j+2 (one-edge bubble).
- With `word_vld` held high, bases are contiguous across word boundaries. A sequence of N bases yields N consecutive `en_out` cycles.
- Bubble rule: if `word_vld` is low for m consecutive cycles starting at the `wcnt==1` cycle, `en_out` is low for exactly m cycles.
- `done` is high exactly LENGTH cycles after the `last_out` cycle. `en_out` is low for the LENGTH-1 cycles between them.
- `start` may be accepted in the cycle `done` is high (state is already IDLE).

## Test plan
- Reset: assert `rst` mid-cycle with stimulus active → all outputs 0 immediately; after release, `word_rdy=0` until `start`.
- `target_len=5`, one word 0x000000E4 → `en_out` high 5 cycles with `data_out` 0,1,2,3,0; `last_out` on the 5th; `done` LENGTH cycles later; exactly one `word_rdy&word_vld` handshake.
- `target_len=40`, BPW=16, `word_vld` constant 1 → 40 contiguous `en_out` cycles, exactly 3 handshakes, 0 bubbles, then one `done` pulse.
- `target_len=32`, `word_vld` low for 3 cycles starting at the `wcnt==1` cycle of word 0 → exactly 3 `en_out`-low cycles between base 15 and base 16; base values preserved.
- `target_len=0` → `done` next cycle, no `word_rdy`, no `en_out`. Also: `start` pulsed during STREAM is ignored; `rem` and the base count are unchanged.
- `rst` asserted during DRAIN, then `start` with `target_len=3` → no `done` from the aborted run; the new run emits 3 bases and one `done`.
